store_buffer: RTL and testbench

Posted-write buffer between the single-cycle RISC-V core's store port (MemWrite, Mem_WrAddr, Mem_WrData) and the data-memory bus. Stores retire from the core in one cycle. The buffer drains them in order over a valid/ready bus, while loads forward data from any still-pending store to the same word. It decouples core timing from bus wait states without adding core stalls, except when the buffer is full.

---
 rtl/store_buf_pkg.sv | 25 ++
 rtl/sb_match.sv | 42 ++++
 rtl/store_buffer.sv | 112 +++++++++++
 tb/tb_store_buffer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buf_pkg.sv
// ============================================================================
// store_buf_pkg : shared types and constants for the store_buffer block
// Revision 1.0
// ============================================================================
`default_nettype none

package store_buf_pkg;

  localparam int DEPTH_DEFAULT  = 4;
  localparam int ADDR_W_DEFAULT = 32;
  localparam int DATA_W_DEFAULT = 32;
  localparam int PTR_W          = $clog2(DEPTH_DEFAULT);

  typedef struct packed {
    logic [ADDR_W_DEFAULT-3:0] addr;
    logic [DATA_W_DEFAULT-1:0] data;
  } sb_entry_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sb_match.sv
// ============================================================================
// sb_match : word-address comparator, youngest pending entry wins
// Revision 1.0
// ============================================================================
`default_nettype none

module sb_match
  import store_buf_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int PW     = ptr_width(DEPTH)
) (
  input  logic [ADDR_W-3:0] entry_addr [DEPTH],
  input  logic [DATA_W-1:0] entry_data [DEPTH],
  input  logic [DEPTH-1:0]  valid,
  input  logic [PW-1:0]     tail,
  input  logic [ADDR_W-3:0] ld_word,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic [PW-1:0] idx;

  // Walk from oldest (tail-DEPTH) to youngest (tail-1); later matches override.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail - PW'(k);
      if (valid[idx] && (entry_addr[idx] == ld_word)) begin
        hit  = 1'b1;
        data = entry_data[idx];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
// store_buffer : posted-write FIFO with load forwarding (STORE_BUF_FWD_EN)
// Revision 1.0
// ============================================================================
`default_nettype none

module store_buffer
  import store_buf_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_en,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              full,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hit,
  output logic [DATA_W-1:0] ld_data,
  output logic              bus_valid,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data,
  input  logic              bus_ready,
  output logic              empty,
  output logic              overflow
);

  localparam int PW    = ptr_width(DEPTH);
  localparam int CNT_W = PW + 1;

  logic [ADDR_W-3:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CNT_W-1:0]  count;
  logic              overflow_q;
  logic              push;
  logic              pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign bus_valid = !empty;
  assign bus_addr  = {addr_mem[head], 2'b00};
  assign bus_data  = data_mem[head];
  assign overflow  = overflow_q;

  assign pop  = bus_valid && bus_ready;
  // A pop frees the head slot this edge, so a full buffer still takes the store.
  assign push = st_en && (!full || pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (st_en && !push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= st_addr[ADDR_W-1:2];
      data_mem[tail] <= st_data;
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic [DEPTH-1:0] valid;
  logic             unused_bits;

  assign unused_bits = ^{st_addr[1:0], ld_addr[1:0]};

  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    logic [PW-1:0] offset;
    assign offset   = PW'(i) - head;
    assign valid[i] = ({1'b0, offset} < count);
  end

  sb_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PW     (PW)
  ) u_match (
    .entry_addr (addr_mem),
    .entry_data (data_mem),
    .valid      (valid),
    .tail       (tail),
    .ld_word    (ld_addr[ADDR_W-1:2]),
    .hit        (ld_hit),
    .data       (ld_data)
  );
`else
  logic unused_bits;

  assign unused_bits = ^{st_addr[1:0], ld_addr};
  assign ld_hit      = 1'b0;
  assign ld_data     = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
// tb_store_buffer : directed and randomized checks against a queue model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_store_buffer;

  localparam int DEPTH = 4;
`ifdef STORE_BUF_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        st_en;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        full;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        bus_valid;
  logic [31:0] bus_addr;
  logic [31:0] bus_data;
  logic        bus_ready;
  logic        empty;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  logic m_ovf = 1'b0;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .st_en     (st_en),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .full      (full),
    .ld_addr   (ld_addr),
    .ld_hit    (ld_hit),
    .ld_data   (ld_data),
    .bus_valid (bus_valid),
    .bus_addr  (bus_addr),
    .bus_data  (bus_data),
    .bus_ready (bus_ready),
    .empty     (empty),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference: pending stores are a plain FIFO queue of the program-order stores.
  function automatic void model_update();
    bit do_pop, do_push;
    ent_t e;
    if (!reset) begin
      q.delete();
      m_ovf = 1'b0;
      return;
    end
    do_pop  = (q.size() > 0) && bus_ready;
    do_push = st_en && ((q.size() < DEPTH) || do_pop);
    if (st_en && !do_push) m_ovf = 1'b1;
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      e.addr = {st_addr[31:2], 2'b00};
      e.data = st_data;
      q.push_back(e);
    end
  endfunction

  function automatic void model_ld(input logic [31:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (!FWD) return;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].addr[31:2] == a[31:2]) begin
        h = 1'b1;
        d = q[i].data;
        return;
      end
    end
  endfunction

  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; st_en = 1'b0; bus_ready = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL init_empty: got %b want 1", empty); end
    n_cmp++; if (bus_valid !== 1'b0) begin n_bad++; $display("FAIL init_bus_valid: got %b want 0", bus_valid); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL init_full: got %b want 0", full); end
    // Five stores into a stalled bus: four pending plus one dropped.
    for (int i = 0; i < 5; i++) begin
      st_en = 1'b1; st_addr = 32'h500 + 32'(i * 4); st_data = $urandom;
      tick();
    end
    st_en = 1'b0; #1;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL pre_rst_overflow: got %b want 1", overflow); end
    reset = 1'b0; bus_ready = 1'b1;
    tick();
    reset = 1'b1; bus_ready = 1'b0; ld_addr = 32'h500; #1;
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty: got %b want 1", empty); end
    n_cmp++; if (bus_valid !== 1'b0) begin n_bad++; $display("FAIL rst_bus_valid: got %b want 0", bus_valid); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    n_cmp++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin n_bad++; $display("FAIL rst_ld: got %b/%h want 0/0", ld_hit, ld_data); end
  endtask

  task automatic test_drain_order();
    do_reset();
    bus_ready = 1'b1; st_en = 1'b1; st_addr = 32'h100; st_data = 32'hAAAA; #1;
    n_cmp++; if (bus_valid !== 1'b0) begin n_bad++; $display("FAIL drain_c0_valid: got %b want 0", bus_valid); end
    tick();
    st_addr = 32'h104; st_data = 32'hBBBB; #1;
    n_cmp++; if (bus_valid !== 1'b1 || bus_addr !== 32'h100 || bus_data !== 32'hAAAA) begin
      n_bad++; $display("FAIL drain_c1: got %b/%h/%h want 1/100/aaaa", bus_valid, bus_addr, bus_data); end
    tick();
    st_en = 1'b0; #1;
    n_cmp++; if (bus_valid !== 1'b1 || bus_addr !== 32'h104 || bus_data !== 32'hBBBB) begin
      n_bad++; $display("FAIL drain_c2: got %b/%h/%h want 1/104/bbbb", bus_valid, bus_addr, bus_data); end
    tick();
    #1;
    n_cmp++; if (empty !== 1'b1 || bus_valid !== 1'b0) begin n_bad++; $display("FAIL drain_c3: got empty=%b valid=%b want 1/0", empty, bus_valid); end
  endtask

  task automatic test_full_overflow();
    logic [31:0] exp_a [5];
    logic [31:0] exp_d [5];
    do_reset();
    bus_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st_en = 1'b1; st_addr = 32'h1000 + 32'(i * 4); st_data = $urandom;
      exp_a[i] = st_addr; exp_d[i] = st_data;
      tick();
    end
    st_en = 1'b0; #1;
    n_cmp++; if (full !== 1'b1 || empty !== 1'b0) begin n_bad++; $display("FAIL full_set: got full=%b empty=%b want 1/0", full, empty); end
    st_en = 1'b1; st_addr = 32'h200; st_data = 32'h5;
    tick();
    st_en = 1'b0; #1;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
    n_cmp++; if (full !== 1'b1 || bus_addr !== 32'h1000) begin n_bad++; $display("FAIL ovf_hold: got full=%b addr=%h want 1/1000", full, bus_addr); end
    st_en = 1'b1; st_addr = 32'h204; st_data = 32'h6; bus_ready = 1'b1;
    exp_a[4] = 32'h204; exp_d[4] = 32'h6;
    tick();
    st_en = 1'b0; bus_ready = 1'b0; #1;
    n_cmp++; if (full !== 1'b1 || bus_addr !== 32'h1004 || overflow !== 1'b1) begin
      n_bad++; $display("FAIL full_pushpop: got full=%b addr=%h ovf=%b want 1/1004/1", full, bus_addr, overflow); end
    bus_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      #1;
      n_cmp++; if (bus_valid !== 1'b1 || bus_addr !== exp_a[i] || bus_data !== exp_d[i]) begin
        n_bad++; $display("FAIL full_drain%0d: got %b/%h/%h want 1/%h/%h", i, bus_valid, bus_addr, bus_data, exp_a[i], exp_d[i]); end
      tick();
    end
    #1;
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL full_drained: got %b want 1", empty); end
    bus_ready = 1'b0;
  endtask

  task automatic test_forward();
    do_reset();
    bus_ready = 1'b0;
    st_en = 1'b1; st_addr = 32'h300; st_data = 32'h11; tick();
    st_data = 32'h22; tick();
    st_en = 1'b0; ld_addr = 32'h302; #1;
    n_cmp++; if (ld_hit !== FWD || ld_data !== (FWD ? 32'h22 : 32'h0)) begin
      n_bad++; $display("FAIL fwd_youngest: got %b/%h want %b/%h", ld_hit, ld_data, FWD, FWD ? 32'h22 : 32'h0); end
    ld_addr = 32'h304; #1;
    n_cmp++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin n_bad++; $display("FAIL fwd_miss: got %b/%h want 0/0", ld_hit, ld_data); end
    bus_ready = 1'b1; #1;
    n_cmp++; if (bus_addr !== 32'h300 || bus_data !== 32'h11) begin n_bad++; $display("FAIL fwd_bus0: got %h/%h want 300/11", bus_addr, bus_data); end
    tick(); #1;
    n_cmp++; if (bus_addr !== 32'h300 || bus_data !== 32'h22) begin n_bad++; $display("FAIL fwd_bus1: got %h/%h want 300/22", bus_addr, bus_data); end
    tick();
    bus_ready = 1'b0;
  endtask

  task automatic test_same_cycle();
    do_reset();
    st_en = 1'b1; st_addr = 32'h40; st_data = 32'h7; ld_addr = 32'h40; #1;
    n_cmp++; if (ld_hit !== 1'b0) begin n_bad++; $display("FAIL same_cycle_hit: got %b want 0", ld_hit); end
    tick();
    st_en = 1'b0; #1;
    n_cmp++; if (ld_hit !== FWD || ld_data !== (FWD ? 32'h7 : 32'h0)) begin
      n_bad++; $display("FAIL next_cycle_hit: got %b/%h want %b/%h", ld_hit, ld_data, FWD, FWD ? 32'h7 : 32'h0); end
  endtask

  task automatic test_random();
    logic        e_hit;
    logic [31:0] e_data;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 59) != 0);
      st_en     = ($urandom_range(0, 9) < 7);
      st_addr   = 32'h800 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
      st_data   = $urandom;
      bus_ready = ($urandom_range(0, 1) == 1);
      ld_addr   = 32'h800 + 32'($urandom_range(0, 6) * 4) + 32'($urandom_range(0, 3));
      #1;
      model_ld(ld_addr, e_hit, e_data);
      n_cmp++; if (full !== (q.size() == DEPTH) || empty !== (q.size() == 0) || bus_valid !== (q.size() != 0)) begin
        n_bad++; $display("FAIL rnd_flags c%0d: got f=%b e=%b v=%b want size=%0d", c, full, empty, bus_valid, q.size()); end
      if (q.size() != 0) begin
        n_cmp++; if (bus_addr !== q[0].addr || bus_data !== q[0].data) begin
          n_bad++; $display("FAIL rnd_bus c%0d: got %h/%h want %h/%h", c, bus_addr, bus_data, q[0].addr, q[0].data); end
      end
      n_cmp++; if (ld_hit !== e_hit || ld_data !== e_data) begin
        n_bad++; $display("FAIL rnd_ld c%0d: got %b/%h want %b/%h", c, ld_hit, ld_data, e_hit, e_data); end
      n_cmp++; if (overflow !== m_ovf) begin n_bad++; $display("FAIL rnd_ovf c%0d: got %b want %b", c, overflow, m_ovf); end
      tick();
    end
    reset = 1'b1; st_en = 1'b0; bus_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; st_en = 1'b0; st_addr = '0; st_data = '0; ld_addr = '0; bus_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_drain_order();
    test_full_overflow();
    test_forward();
    test_same_cycle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
